// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line input and byte-level result signals of the UART receiver
interface uart_rx_if;
  logic       rx;
  logic [7:0] data_out;
  logic       rx_done;
  logic       parity_err;
  logic       frame_err;
  logic       busy;
  modport master (output rx, input data_out, rx_done, parity_err, frame_err, busy);
  modport slave (input rx, output data_out, rx_done, parity_err, frame_err, busy);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8E2 UART receiver (start, 8 data LSB first, even parity, 2 stops) with parity/framing flags; UART_RX_MAJORITY_EN selects 2-of-3 bit voting
module uart_rx #(
  parameter int clk_freq = 1000000,
  parameter int baudrate = 9600
) (
  input  logic     clk,
  input  logic     rst,
  uart_rx_if.slave bus
);
  localparam int BPC  = clk_freq / baudrate;
  localparam int HALF = BPC / 2;
  localparam logic [15:0] LAST = 16'(BPC - 1);
`ifdef UART_RX_MAJORITY_EN
  localparam logic [15:0] START_LAST = 16'(HALF);
`else
  localparam logic [15:0] START_LAST = 16'(HALF - 1);
`endif
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, DONE} state_t;
  state_t      state_q;
  logic        rx_m_q, rx_s_q, rx_prev_q;
  logic [15:0] clk_count_q;
  logic [2:0]  bit_index_q;
  logic [7:0]  shift_q, data_out_q;
  logic        par_s_q, frame_q, rx_done_q, parity_err_q, frame_err_q;
  logic        bit_v, tick;
`ifdef UART_RX_MAJORITY_EN
  logic [1:0]  hist_q;
  // last two synchronized samples; with the current one they form the vote window
  always_ff @(posedge clk or negedge rst)
    if (!rst) hist_q <= 2'b11;
    else hist_q <= {hist_q[0], rx_s_q};
  assign bit_v = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s_q) | (hist_q[0] & rx_s_q);
`else
  assign bit_v = rx_s_q;
`endif
  assign tick = clk_count_q == ((state_q == START) ? START_LAST : LAST);
  // two-flop synchronizer plus delayed copy for falling-edge detection
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rx_m_q    <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_m_q    <= bus.rx;
      rx_s_q    <= rx_m_q;
      rx_prev_q <= rx_s_q;
    end
  // frame FSM: bit timer, data capture, error evaluation and result registers
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q      <= IDLE;
      clk_count_q  <= '0;
      bit_index_q  <= '0;
      shift_q      <= '0;
      par_s_q      <= 1'b0;
      frame_q      <= 1'b0;
      data_out_q   <= '0;
      rx_done_q    <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_done_q <= 1'b0;
      if (state_q != IDLE && state_q != DONE) clk_count_q <= tick ? '0 : clk_count_q + 16'd1;
      case (state_q)
        IDLE: if (rx_prev_q && !rx_s_q) state_q <= START;
        START: if (tick) begin
          bit_index_q <= '0;
          state_q     <= bit_v ? IDLE : DATA;
        end
        DATA: if (tick) begin
          shift_q[bit_index_q] <= bit_v;
          bit_index_q          <= bit_index_q + 3'd1;
          if (bit_index_q == 3'd7) state_q <= PARITY;
        end
        PARITY: if (tick) begin
          par_s_q <= bit_v;
          state_q <= STOP1;
        end
        STOP1: if (tick) begin
          frame_q <= !bit_v;
          state_q <= STOP2;
        end
        STOP2: if (tick) begin
          data_out_q   <= shift_q;
          parity_err_q <= par_s_q ^ (^shift_q);
          frame_err_q  <= frame_q | !bit_v;
          rx_done_q    <= 1'b1;
          state_q      <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  assign bus.data_out   = data_out_q;
  assign bus.rx_done    = rx_done_q;
  assign bus.parity_err = parity_err_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.busy       = state_q != IDLE;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized frame-level bench for uart_rx, expected results from a byte/parity/stop reference model
module tb_uart_rx;
  localparam int CLK_FREQ = 1000000;
  localparam int BAUD = 9600;
  localparam int BPC = CLK_FREQ / BAUD;
  localparam int HALF = BPC / 2;
`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif
  localparam int LAT = 2 + HALF + 11 * BPC + 1 + MAJ;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int checks = 0;
  int fails = 0;
  int viol = 0;
  int t0 = 0;
  logic [9:0] got_v[$];
  int got_c[$];
  logic [9:0] last_v = '0;
  logic last_done = 1'b0;
  uart_rx_if bus();
  uart_rx #(.clk_freq(CLK_FREQ), .baudrate(BAUD)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // record every result pulse; flag result changes outside rx_done and pulses longer than one cycle
  always @(negedge clk) begin
    if (bus.rx_done) begin
      got_v.push_back({bus.data_out, bus.parity_err, bus.frame_err});
      got_c.push_back(cyc);
    end
    if (rst && ((!bus.rx_done && {bus.data_out, bus.parity_err, bus.frame_err} != last_v) || (bus.rx_done && last_done))) viol++;
    last_v = {bus.data_out, bus.parity_err, bus.frame_err};
    last_done = bus.rx_done;
  end
  task automatic idle(input int n);
    bus.rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask
  task automatic send_frame(input logic [7:0] d, input logic par, input logic s1, input logic s2, input bit inv, input int cut);
    logic [11:0] f;
    int n;
    f = {s2, s1, par, d, 1'b0};
    n = 0;
    for (int b = 0; b < 12; b++)
      for (int c = 0; c < BPC; c++) begin
        if (cut != 0 && n == cut) return;
        @(negedge clk);
        if (n == 0) t0 = cyc;
        bus.rx = (inv && c == HALF) ? ~f[b] : f[b];
        n++;
      end
  endtask
  task automatic test_reset;
    bus.rx = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.data_out, bus.rx_done, bus.parity_err, bus.frame_err, bus.busy} !== 12'h0) begin
      fails++;
      $display("FAIL reset outputs: got %h, want 000", {bus.data_out, bus.rx_done, bus.parity_err, bus.frame_err, bus.busy});
    end
    rst = 1'b1;
    idle(20);
    checks++;
    if (bus.busy !== 1'b0 || got_v.size() != 0) begin
      fails++;
      $display("FAIL reset idle: busy=%b pulses=%0d, want busy=0 pulses=0", bus.busy, got_v.size());
    end
  endtask
  task automatic test_random;
    logic [7:0] d;
    logic par, s1, s2;
    logic [9:0] exp_v, v;
    int lat;
    for (int i = 0; i < 8; i++) begin
      d = (i == 0) ? 8'hA5 : 8'($urandom);
      par = (^d) ^ ((i > 0) && ($urandom_range(3) == 0));
      s1 = !((i > 0) && ($urandom_range(4) == 0));
      s2 = !((i > 0) && ($urandom_range(4) == 0));
      exp_v = {d, par != ^d, !(s1 && s2)};
      got_v.delete();
      got_c.delete();
      send_frame(d, par, s1, s2, 1'b0, 0);
      idle(BPC);
      checks++;
      if (got_v.size() != 1) begin
        fails++;
        $display("FAIL random[%0d] pulses: got %0d, want 1", i, got_v.size());
      end else begin
        v = got_v.pop_front();
        lat = got_c.pop_front() - t0;
        checks++;
        if (v !== exp_v) begin
          fails++;
          $display("FAIL random[%0d] result {data,pe,fe}: got %h/%b/%b, want %h/%b/%b", i, v[9:2], v[1], v[0], exp_v[9:2], exp_v[1], exp_v[0]);
        end
        checks++;
        if (lat < LAT - 2 || lat > LAT + 2) begin
          fails++;
          $display("FAIL random[%0d] latency: got %0d, want %0d+-2", i, lat, LAT);
        end
      end
    end
  endtask
  task automatic test_parity;
    got_v.delete();
    send_frame(8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 0);
    idle(BPC);
    checks++;
    if (got_v.size() != 1 || got_v[0] !== {8'h01, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL parity_err frame: pulses=%0d got %h, want 1 pulse %h", got_v.size(), got_v.size() ? got_v[0] : 10'h0, {8'h01, 1'b1, 1'b0});
    end
  endtask
  task automatic test_frame;
    got_v.delete();
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    idle(BPC);
    send_frame(8'h55, 1'b0, 1'b1, 1'b1, 1'b0, 0);
    idle(BPC);
    checks++;
    if (got_v.size() != 2 || got_v[0] !== {8'h3C, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL frame_err frame: pulses=%0d got %h, want 2 pulses first %h", got_v.size(), got_v.size() ? got_v[0] : 10'h0, {8'h3C, 1'b0, 1'b1});
    end
    checks++;
    if (got_v.size() != 2 || got_v[1] !== {8'h55, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL frame_err recovery: pulses=%0d got %h, want %h", got_v.size(), got_v.size() > 1 ? got_v[1] : 10'h0, {8'h55, 1'b0, 1'b0});
    end
  endtask
  task automatic test_glitch;
    got_v.delete();
    idle(10);
    bus.rx = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1) begin
      fails++;
      $display("FAIL glitch busy_high: got %b, want 1", bus.busy);
    end
    repeat (10) @(negedge clk);
    bus.rx = 1'b1;
    repeat (HALF + 5) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || got_v.size() != 0) begin
      fails++;
      $display("FAIL glitch reject: busy=%b pulses=%0d, want busy=0 pulses=0", bus.busy, got_v.size());
    end
    send_frame(8'h81, 1'b0, 1'b1, 1'b1, 1'b0, 0);
    idle(BPC);
    checks++;
    if (got_v.size() != 1 || got_v[0] !== {8'h81, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL glitch next frame: pulses=%0d got %h, want 1 pulse %h", got_v.size(), got_v.size() ? got_v[0] : 10'h0, {8'h81, 1'b0, 1'b0});
    end
  endtask
  task automatic test_back_to_back;
    got_v.delete();
    send_frame(8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 0);
    send_frame(8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 0);
    idle(BPC);
    checks++;
    if (got_v.size() != 2) begin
      fails++;
      $display("FAIL back_to_back pulses: got %0d, want 2", got_v.size());
    end else begin
      checks++;
      if (got_v[0] !== {8'h00, 1'b0, 1'b0} || got_v[1] !== {8'hFF, 1'b0, 1'b0}) begin
        fails++;
        $display("FAIL back_to_back results: got %h %h, want %h %h", got_v[0], got_v[1], {8'h00, 2'b00}, {8'hFF, 2'b00});
      end
    end
  endtask
  task automatic test_rst_mid;
    got_v.delete();
    send_frame(8'h5A, 1'b0, 1'b1, 1'b1, 1'b0, HALF + 5 * BPC);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.data_out, bus.rx_done, bus.parity_err, bus.frame_err, bus.busy} !== 12'h0) begin
      fails++;
      $display("FAIL rst_mid outputs: got %h, want 000", {bus.data_out, bus.rx_done, bus.parity_err, bus.frame_err, bus.busy});
    end
    bus.rx = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    idle(20);
    send_frame(8'h7E, 1'b0, 1'b1, 1'b1, MAJ != 0, 0);
    idle(BPC);
    checks++;
    if (got_v.size() != 1 || got_v[0] !== {8'h7E, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL rst_mid next frame: pulses=%0d got %h, want 1 pulse %h", got_v.size(), got_v.size() ? got_v[0] : 10'h0, {8'h7E, 1'b0, 1'b0});
    end
  endtask
  task automatic test_break;
    got_v.delete();
    send_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    repeat (3 * BPC) @(negedge clk);
    checks++;
    if (got_v.size() != 1 || got_v[0] !== {8'h00, 1'b0, 1'b1} || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL break frame: pulses=%0d got %h busy=%b, want 1 pulse %h busy=0", got_v.size(), got_v.size() ? got_v[0] : 10'h0, bus.busy, {8'h00, 1'b0, 1'b1});
    end
    idle(BPC);
    checks++;
    if (got_v.size() != 1 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL break release: pulses=%0d busy=%b, want 1 pulse busy=0", got_v.size(), bus.busy);
    end
  endtask
  task automatic test_hold;
    checks++;
    if (viol != 0) begin
      fails++;
      $display("FAIL result hold/pulse width: got %0d violations, want 0", viol);
    end
  endtask
  initial begin
    test_reset;
    test_random;
    test_parity;
    test_frame;
    test_glitch;
    test_back_to_back;
    test_rst_mid;
    test_break;
    test_hold;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
